// File: rtl/alu_pkg.sv
// Shared definitions for the ALU multiply/divide sequencer: opcode codes,
// sequencer state encoding and a small opcode classification helper.
package alu_pkg;

  localparam logic [4:0] ALU_OP_MUL = 5'b00010;
  localparam logic [4:0] ALU_OP_DIV = 5'b00011;
  localparam logic [4:0] ALU_OP_MOD = 5'b00100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // True for the two opcodes that run through the restoring divider.
  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALU_OP_DIV) || (code == ALU_OP_MOD);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Combinational two's-complement conditional negate. With negate tied to
// the operand's sign bit it yields the absolute value (|-2^(W-1)| is the
// unsigned 2^(W-1)); with negate tied to a result sign it applies the sign fix.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  // Invert-and-increment when negation is requested, otherwise pass through.
  always_comb begin
    if (negate) begin
      result = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply / divide / modulo sequencer for the ALU execute stage.
// Radix-2 shift-add multiply and restoring division on operand magnitudes,
// with a sign fix on the final iteration. valid/ready on both sides.
// Optional build macro MULDIV_EARLY_EXIT_EN: MUL leaves CALC as soon as the
// remaining multiplier bits are zero (results are unchanged).
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic             bad_op,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  // Architectural state
  muldiv_state_e    state_r, state_s;
  logic [OP_W-1:0]  op_r, op_s;
  logic             neg_r, neg_s;
  logic [WIDTH-1:0] acc_r, acc_s;   // product accumulator / partial remainder
  logic [WIDTH-1:0] sh_r, sh_s;     // multiplier (shifts right) / dividend->quotient (shifts left)
  logic [WIDTH-1:0] opd_r, opd_s;   // multiplicand (shifts left) / divisor (constant)
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             div_zero_r, div_zero_s;
  logic             bad_op_r, bad_op_s;
  logic             in_ready_r, out_valid_r, busy_r;

  // Iteration datapath
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] step_acc_s, step_sh_s, step_opd_s;
  logic [WIDTH-1:0] mag_s;
  logic             last_s;

  // Operand entry and sign fix
  logic [WIDTH-1:0] abs_a_s, abs_b_s, fixed_s;
  logic             b_zero_s;

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value  (a),
    .negate (a[WIDTH-1]),
    .result (abs_a_s)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value  (b),
    .negate (b[WIDTH-1]),
    .result (abs_b_s)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_sign_fix (
    .value  (mag_s),
    .negate (neg_r),
    .result (fixed_s)
  );

  assign b_zero_s = (b == {WIDTH{1'b0}});

  // One radix-2 step: shift-add for MUL, restoring subtract for DIV/MOD.
  always_comb begin
    rem_sh_s   = {acc_r, sh_r[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, opd_r};
    step_acc_s = acc_r;
    step_sh_s  = sh_r;
    step_opd_s = opd_r;
    if (op_r == ALU_OP_MUL) begin
      if (sh_r[0]) begin
        step_acc_s = acc_r + opd_r;
      end else begin
        step_acc_s = acc_r;
      end
      step_sh_s  = {1'b0, sh_r[WIDTH-1:1]};
      step_opd_s = {opd_r[WIDTH-2:0], 1'b0};
    end else if (!diff_s[WIDTH]) begin
      step_acc_s = diff_s[WIDTH-1:0];
      step_sh_s  = {sh_r[WIDTH-2:0], 1'b1};
      step_opd_s = opd_r;
    end else begin
      step_acc_s = rem_sh_s[WIDTH-1:0];
      step_sh_s  = {sh_r[WIDTH-2:0], 1'b0};
      step_opd_s = opd_r;
    end
  end

  // Pick the magnitude to sign-fix and decide whether this is the last step.
  always_comb begin
    case (op_r)
      ALU_OP_MUL: mag_s = step_acc_s;
      ALU_OP_DIV: mag_s = step_sh_s;
      default:    mag_s = step_acc_s;
    endcase
`ifdef MULDIV_EARLY_EXIT_EN
    last_s = (cnt_r == {CNT_W{1'b0}}) ||
             ((op_r == ALU_OP_MUL) && (step_sh_s == {WIDTH{1'b0}}));
`else
    last_s = (cnt_r == {CNT_W{1'b0}});
`endif
  end

  // Next-state and next-datapath logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    neg_s      = neg_r;
    acc_s      = acc_r;
    sh_s       = sh_r;
    opd_s      = opd_r;
    cnt_s      = cnt_r;
    result_s   = result_r;
    div_zero_s = div_zero_r;
    bad_op_s   = bad_op_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          op_s       = op;
          acc_s      = {WIDTH{1'b0}};
          cnt_s      = CNT_W'(WIDTH - 1);
          div_zero_s = 1'b0;
          bad_op_s   = 1'b0;
          if (op == ALU_OP_MUL) begin
            neg_s   = a[WIDTH-1] ^ b[WIDTH-1];
            sh_s    = abs_b_s;
            opd_s   = abs_a_s;
            state_s = CALC;
          end else if (is_div_op(op)) begin
            if (op == ALU_OP_MOD) begin
              neg_s = a[WIDTH-1];
            end else begin
              neg_s = a[WIDTH-1] ^ b[WIDTH-1];
            end
            sh_s  = abs_a_s;
            opd_s = abs_b_s;
            if (b_zero_s) begin
              // Zero divisor bypasses the engine: DIV -> all ones, MOD -> a.
              div_zero_s = 1'b1;
              state_s    = DONE;
              if (op == ALU_OP_DIV) begin
                result_s = {WIDTH{1'b1}};
              end else begin
                result_s = a;
              end
            end else begin
              state_s = CALC;
            end
          end else begin
            bad_op_s = 1'b1;
            result_s = {WIDTH{1'b0}};
            state_s  = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        acc_s = step_acc_s;
        sh_s  = step_sh_s;
        opd_s = step_opd_s;
        if (last_s) begin
          cnt_s    = {CNT_W{1'b0}};
          result_s = fixed_s;
          state_s  = DONE;
        end else begin
          cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      op_r        <= {OP_W{1'b0}};
      neg_r       <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
      sh_r        <= {WIDTH{1'b0}};
      opd_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      div_zero_r  <= 1'b0;
      bad_op_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      neg_r       <= neg_s;
      acc_r       <= acc_s;
      sh_r        <= sh_s;
      opd_r       <= opd_s;
      cnt_r       <= cnt_s;
      result_r    <= result_s;
      div_zero_r  <= div_zero_s;
      bad_op_r    <= bad_op_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = result_r;
  assign div_zero  = div_zero_r;
  assign bad_op    = bad_op_r;

endmodule
